// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-outstanding CPU load/store controller routing to block RAM or MMIO,
// with MMIO stall handling, wait timeout and byte-lane read data selection.
module mem_bus_ctrl #(
  parameter logic [15:0] MMIO_BASE    = 16'hff00,
  parameter logic [7:0]  WAIT_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic        ram_en,
  output logic        ram_we,
  output logic [14:0] ram_addr,
  output logic        ram_byte_select,
  output logic        ram_byte_enable,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        mmio_en,
  output logic        mmio_write_enable,
  output logic [15:0] mmio_addr,
  output logic        mmio_byte_select,
  output logic        mmio_byte_enable,
  output logic [15:0] mmio_data_in,
  input  logic [15:0] mmio_data_out,
  input  logic        mmio_wait
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RDATA = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;
  logic [1:0]  state;
  logic [15:0] addr, wdata;
  logic        we, byte_acc, is_mmio;
  logic [7:0]  wait_cnt;
  logic        mmio_stalled, timeout;
  logic [15:0] src, load_data;
  assign mmio_stalled = state == ISSUE && is_mmio && mmio_wait;
  assign timeout = mmio_stalled && WAIT_TIMEOUT != 8'd0 && wait_cnt == WAIT_TIMEOUT - 8'd1;
  assign src = is_mmio ? mmio_data_out : ram_rdata;
  // MMIO already delivers the addressed byte in [7:0]; RAM needs lane selection
  assign load_data = !byte_acc ? src :
                     (!is_mmio && addr[0]) ? {8'h00, src[15:8]} : {8'h00, src[7:0]};
  assign ram_addr          = addr[15:1];
  assign ram_byte_select   = addr[0];
  assign ram_byte_enable   = byte_acc;
  assign ram_wdata         = wdata;
  assign mmio_addr         = {1'b0, addr[15:1]};
  assign mmio_byte_select  = addr[0];
  assign mmio_byte_enable  = byte_acc;
  assign mmio_data_in      = wdata;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      addr              <= '0;
      wdata             <= '0;
      we                <= 1'b0;
      byte_acc          <= 1'b0;
      is_mmio           <= 1'b0;
      wait_cnt          <= '0;
      cpu_rdata         <= '0;
      cpu_ack           <= 1'b0;
      cpu_err           <= 1'b0;
      cpu_busy          <= 1'b0;
      ram_en            <= 1'b0;
      ram_we            <= 1'b0;
      mmio_en           <= 1'b0;
      mmio_write_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cpu_req) begin
          state             <= ISSUE;
          addr              <= cpu_addr;
          wdata             <= cpu_wdata;
          we                <= cpu_we;
          byte_acc          <= cpu_byte;
          is_mmio           <= cpu_addr >= MMIO_BASE;
          cpu_busy          <= 1'b1;
          ram_en            <= cpu_addr < MMIO_BASE;
          ram_we            <= cpu_addr < MMIO_BASE && cpu_we;
          mmio_en           <= cpu_addr >= MMIO_BASE;
          mmio_write_enable <= cpu_addr >= MMIO_BASE && cpu_we;
        end
        ISSUE: if (mmio_stalled && !timeout) begin
          wait_cnt <= wait_cnt + 8'd1;
        end else begin
          ram_en            <= 1'b0;
          ram_we            <= 1'b0;
          mmio_en           <= 1'b0;
          mmio_write_enable <= 1'b0;
          state             <= (we || timeout) ? ACK : RDATA;
          cpu_ack           <= we || timeout;
          cpu_err           <= timeout;
          if (timeout) cpu_rdata <= '0;
        end
        RDATA: begin
          cpu_rdata <= load_data;
          cpu_ack   <= 1'b1;
          state     <= ACK;
        end
        default: begin
          cpu_ack  <= 1'b0;
          cpu_err  <= 1'b0;
          cpu_busy <= 1'b0;
          wait_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed checks of mem_bus_ctrl (WAIT_TIMEOUT = 4) against hand-computed values.
module tb_mem_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_byte = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack, cpu_err, cpu_busy;
  logic        ram_en, ram_we, ram_byte_select, ram_byte_enable;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic        mmio_en, mmio_write_enable, mmio_byte_select, mmio_byte_enable;
  logic [15:0] mmio_addr, mmio_data_in;
  logic [15:0] mmio_data_out = '0;
  logic        mmio_wait = 1'b0;
  int          n_chk = 0, n_fail = 0;
  mem_bus_ctrl #(.MMIO_BASE(16'hff00), .WAIT_TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_byte_select(ram_byte_select), .ram_byte_enable(ram_byte_enable),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .mmio_en(mmio_en), .mmio_write_enable(mmio_write_enable), .mmio_addr(mmio_addr),
    .mmio_byte_select(mmio_byte_select), .mmio_byte_enable(mmio_byte_enable),
    .mmio_data_in(mmio_data_in), .mmio_data_out(mmio_data_out), .mmio_wait(mmio_wait)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // presents a request for edge 0 and returns 1ns into cycle 1
  task automatic go(input logic we, input logic bt, input logic [15:0] a, input logic [15:0] d);
    cpu_we = we; cpu_byte = bt; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
  endtask
  initial begin
    int acks;
    cpu_req = 1'b1;
    tick(); tick();
    check("rst_strobes", {ram_en, ram_we, mmio_en, mmio_write_enable}, 0);
    check("rst_status", {cpu_ack, cpu_err, cpu_busy}, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_addr", {ram_addr, mmio_addr}, 0);
    cpu_req = 1'b0;
    rst = 1'b1;
    tick();
    // word load from RAM
    ram_rdata = 16'hbeef;
    go(1'b0, 1'b0, 16'h0010, 16'h0);
    check("ld_c1_ram_en", {ram_en, ram_we, mmio_en}, 3'b100);
    check("ld_c1_ram_addr", ram_addr, 15'h0008);
    check("ld_c1_busy", cpu_busy, 1);
    tick();
    check("ld_c2_ack", {cpu_ack, ram_en}, 0);
    tick();
    check("ld_c3_ack", {cpu_ack, cpu_err}, 2'b10);
    check("ld_c3_rdata", cpu_rdata, 16'hbeef);
    tick();
    check("ld_c4_idle", {cpu_ack, cpu_busy}, 0);
    // byte loads, both lanes
    ram_rdata = 16'h12ab;
    go(1'b0, 1'b1, 16'h0011, 16'h0);
    check("bl_hi_sel", {ram_byte_select, ram_byte_enable}, 2'b11);
    tick(); tick();
    check("bl_hi_rdata", {cpu_ack, cpu_rdata}, {1'b1, 16'h0012});
    tick();
    go(1'b0, 1'b1, 16'h0010, 16'h0);
    tick(); tick();
    check("bl_lo_rdata", {cpu_ack, cpu_rdata}, {1'b1, 16'h00ab});
    tick();
    // RAM/MMIO boundary on the RAM side
    go(1'b0, 1'b1, 16'hfeff, 16'h0);
    check("bnd_feff_ram", {ram_en, mmio_en}, 2'b10);
    tick(); tick();
    check("bnd_feff_rdata", {cpu_ack, cpu_rdata}, {1'b1, 16'h0012});
    tick();
    // MMIO store
    go(1'b1, 1'b0, 16'hff00, 16'h005a);
    check("st_c1_mmio", {mmio_en, mmio_write_enable, ram_en, ram_we}, 4'b1100);
    check("st_c1_addr", {mmio_addr, mmio_byte_select}, {16'h7f80, 1'b0});
    check("st_c1_data", mmio_data_in, 16'h005a);
    tick();
    check("st_c2_ack", {cpu_ack, cpu_err, mmio_en}, 3'b100);
    check("st_keeps_rdata", cpu_rdata, 16'h0012);
    tick();
    // MMIO load with 3 stall cycles
    mmio_data_out = 16'h0041;
    go(1'b0, 1'b0, 16'hff02, 16'h0);
    for (int i = 0; i < 4; i++) begin
      mmio_wait = i < 3;
      check($sformatf("stall_c%0d_en", i + 1), {mmio_en, cpu_ack, ram_en}, 3'b100);
      tick();
    end
    mmio_wait = 1'b0;
    check("stall_c5", {mmio_en, cpu_ack}, 0);
    tick();
    check("stall_c6_ack", {cpu_ack, cpu_err}, 2'b10);
    check("stall_c6_rdata", cpu_rdata, 16'h0041);
    tick();
    // top byte of MMIO window
    mmio_data_out = 16'h3477;
    go(1'b0, 1'b1, 16'hffff, 16'h0);
    check("ffff_decode", {mmio_en, ram_en, mmio_addr, mmio_byte_select}, {2'b10, 16'h7fff, 1'b1});
    tick(); tick();
    check("ffff_rdata", {cpu_ack, cpu_rdata}, {1'b1, 16'h0077});
    tick();
    // timeout with wait stuck high
    mmio_wait = 1'b1;
    go(1'b0, 1'b0, 16'hff04, 16'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_c%0d_en", i + 1), {mmio_en, cpu_ack}, 2'b10);
      tick();
    end
    check("to_c5_ack", {mmio_en, cpu_ack, cpu_err}, 3'b011);
    check("to_c5_rdata", cpu_rdata, 0);
    tick();
    check("to_c6_clear", {cpu_ack, cpu_err, cpu_busy}, 0);
    mmio_wait = 1'b0;
    tick();
    // back-to-back stores with cpu_req held high
    cpu_we = 1'b1; cpu_byte = 1'b0; cpu_addr = 16'h0020; cpu_wdata = 16'h1234; cpu_req = 1'b1;
    tick();
    check("b2b_c1_en", {ram_en, ram_we}, 2'b11);
    tick();
    check("b2b_c2_ack", cpu_ack, 1);
    tick();
    check("b2b_c3_idle", {cpu_busy, ram_en, cpu_ack}, 0);
    tick();
    check("b2b_c4_en", {ram_en, ram_we, cpu_busy}, 3'b111);
    cpu_req = 1'b0;
    tick();
    check("b2b_c5_ack", cpu_ack, 1);
    tick();
    // reset in the middle of an access
    go(1'b0, 1'b0, 16'h0030, 16'h0);
    check("mr_c1_en", ram_en, 1);
    rst = 1'b0;
    #1;
    check("mr_async_drop", {ram_en, cpu_busy, cpu_ack}, 0);
    tick();
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acks += int'(cpu_ack);
    end
    check("mr_no_ack", acks, 0);
    check("mr_idle", {cpu_busy, ram_en, mmio_en}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
